spi_slave_rx: RTL
=================

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 SHALL have parameter SLAVE_ID, default 2'd0: the Spis.ss code that selects this slave.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: receive FIFO entries, power of two, 2..16.
REQ-003 SHALL have parameter IDLE_TO, default 8'd32: Clk_i cycles without an sck rise before a partial byte is discarded.
REQ-004 Clk_i  input  1  system clock, all state on rising edge.
REQ-005 Rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 Spis  SPIbus.Slave  -  sck, mosi, ss[1:0] inputs from the SPI master.
REQ-007 Data_o  output  8  received byte at FIFO head.
REQ-008 Valid_o  output  1  FIFO non-empty.
REQ-009 Ready_i  input  1  consumer accepts Data_o when Valid_o&Ready_i.
REQ-010 Count_o  output  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
REQ-011 Overrun_o  output  1  sticky: a complete byte was dropped because the FIFO was full.
REQ-012 Clr_i  input  1  synchronous clear of Overrun_o.

Function
REQ-013 sck, mosi and ss SHALL each pass through a 2-flop synchronizer; rise = sck_s2 & ~sck_s3 (third stage for edge detect).
REQ-014 Selected SHALL be (ss_s2 == SLAVE_ID); bit sampling on rise only while selected.
REQ-015 Bits SHALL be LSB first: shift {mosi_s2, rx[7:1]} on each qualifying rise.
REQ-016 FSM states IDLE, SHIFT; IDLE->SHIFT on first qualifying rise (bit 0 captured, bitcnt=1); SHIFT increments bitcnt per rise.
REQ-017 On the 8th rise the byte SHALL be pushed, bitcnt cleared, FSM -> IDLE.
REQ-018 Latency: rise detected in cycle N -> FIFO write at end of N -> Valid_o/Data_o valid from N+1 when FIFO was empty.
REQ-019 Deselect (ss_s2 != SLAVE_ID) in SHIFT SHALL discard the partial byte and return to IDLE next cycle.
REQ-020 Push when full and no pop in same cycle SHALL drop the byte and set Overrun_o; FIFO contents unchanged.
REQ-021 Push and pop in same cycle SHALL succeed at any occupancy incl. full; Count_o unchanged.
REQ-022 Pop when empty SHALL be ignored; Data_o undefined but stable when Valid_o=0.
REQ-023 Clr_i coincident with a new overrun SHALL leave Overrun_o set (set wins).
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; Count_o never exceeds FIFO_DEPTH.

Reset
REQ-025 Rst_ni low SHALL immediately force: FSM IDLE, bitcnt 0, rx 8'h00, synchronizers 0, FIFO empty, Valid_o 0, Count_o 0, Overrun_o 0, Data_o 8'h00.
REQ-026 Reset mid-byte SHALL discard the partial byte; reception restarts at the next qualifying rise after release.

Configuration
REQ-027 Macro SPI_SLAVE_RX_TIMEOUT_EN defined: in SHIFT, an idle counter reloads on each rise; reaching IDLE_TO SHALL discard the partial byte and return to IDLE.
REQ-028 Macro undefined: no idle counter; partial byte held indefinitely until completed, deselect, or reset; IDLE_TO unused.

Structure
REQ-029 spi_pkg SHALL hold ss width constant, byte_t (logic [7:0]) and the rx_state_e enum {IDLE, SHIFT}.
REQ-030 FIFO SHALL be sub-module spi_rx_fifo (parameterised depth/width, push/pop/full/empty/count); synchronizers and FSM stay in spi_slave_rx.

Verification
REQ-031 Master CLKDIV=4, ss=0, byte 8'hA5, Ready_i=1 -> one Valid_o&Ready_i beat with Data_o=8'hA5, Overrun_o=0.
REQ-032 ss=2'd1 (not SLAVE_ID), byte 8'h3C -> Valid_o stays 0, Count_o=0.
REQ-033 Ready_i=0, FIFO_DEPTH=4, send 8'h01..8'h05 -> Count_o=4, Overrun_o=1, drain yields 01,02,03,04; Clr_i pulse -> Overrun_o=0.
REQ-034 ss switched to 2'd3 after 4 bits of 8'hFF, then full byte 8'h12 at ss=0 -> only 8'h12 received.
REQ-035 TIMEOUT_EN, IDLE_TO=32: 3 bits then 40 idle cycles, then byte 8'h81 -> only 8'h81 received; without macro -> first received byte is the combined bits, not 8'h81.
REQ-036 Rst_ni pulsed after 5 bits of 8'hC3, then full byte 8'h5A -> all outputs at reset values during reset, then single byte 8'h5A.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave receive path.
// The optional idle timeout in spi_slave_rx is enabled by the SPI_SLAVE_RX_TIMEOUT_EN macro.
package spi_pkg;

   localparam int SS_W = 2;

   typedef logic [7:0] byte_t;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } rx_state_e;

endpackage

// File: rtl/spi_bus_if.sv
// SPI bus bundle between a master and its slaves: serial clock, data and a
// binary-coded slave-select field.
interface SPIbus;

   logic                      sck;
   logic                      mosi;
   logic [spi_pkg::SS_W-1:0]  ss;

   modport Master (output sck, output mosi, output ss);
   modport Slave  (input sck, input mosi, input ss);

endinterface

// File: rtl/spi_rx_fifo.sv
// Small synchronous FIFO for received bytes. A push into a full FIFO is
// accepted only if a pop happens in the same cycle; a pop from an empty FIFO
// is ignored. DEPTH must be a power of two so the pointers wrap naturally.
module spi_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                         Clk_i,
   input  logic                         Rst_ni,
   input  logic                         push_i,
   input  logic [WIDTH-1:0]             data_i,
   input  logic                         pop_i,
   output logic [WIDTH-1:0]             data_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign push_ok = push_i & (~full_o | pop_i);
   assign pop_ok  = pop_i & ~empty_o;
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Next-state for storage, pointers and occupancy
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO register state, cleared to empty with zeroed storage on reset
   always_ff @(posedge Clk_i or negedge Rst_ni) begin
      if (!Rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave receiver: synchronizes the bus into Clk_i, assembles LSB-first
// bytes while selected, and queues them in a receive FIFO with sticky overrun.
// Define SPI_SLAVE_RX_TIMEOUT_EN to discard a partial byte after IDLE_TO
// Clk_i cycles without an sck rise.
module spi_slave_rx
   import spi_pkg::*;
#(
   parameter logic [SS_W-1:0] SLAVE_ID   = 2'd0,
   parameter int              FIFO_DEPTH = 4,
   parameter logic [7:0]      IDLE_TO    = 8'd32
) (
   input  logic                                Clk_i,
   input  logic                                Rst_ni,
   SPIbus.Slave                                Spis,
   output logic [7:0]                          Data_o,
   output logic                                Valid_o,
   input  logic                                Ready_i,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]     Count_o,
   output logic                                Overrun_o,
   input  logic                                Clr_i
);

   logic [2:0]            sck_sync_q, sck_sync_d;
   logic [1:0]            mosi_sync_q, mosi_sync_d;
   logic [1:0][SS_W-1:0]  ss_sync_q, ss_sync_d;

   rx_state_e             state_q, state_d;
   logic [2:0]            bitcnt_q, bitcnt_d;
   byte_t                 rx_q, rx_d;
   logic                  overrun_q, overrun_d;

   logic                  rise;
   logic                  selected;
   byte_t                 rx_shift;
   logic                  push;
   logic                  fifo_full;
   logic                  fifo_empty;

   assign rise     = sck_sync_q[1] & ~sck_sync_q[2];
   assign selected = (ss_sync_q[1] == SLAVE_ID);
   assign rx_shift = {mosi_sync_q[1], rx_q[7:1]};

`ifdef SPI_SLAVE_RX_TIMEOUT_EN
   logic [7:0] idle_cnt_q, idle_cnt_d;
   logic       idle_timeout;

   assign idle_timeout = ({1'b0, idle_cnt_q} + 9'd1) >= {1'b0, IDLE_TO};
`else
   logic unused_idle_to;

   assign unused_idle_to = ^IDLE_TO;
`endif

   // Shift each bus signal one stage further down its synchronizer chain
   always_comb begin
      sck_sync_d  = {sck_sync_q[1:0], Spis.sck};
      mosi_sync_d = {mosi_sync_q[0], Spis.mosi};
      ss_sync_d   = {ss_sync_q[0], Spis.ss};
   end

   // Byte assembly FSM: capture bits on qualifying rises, push on the eighth
   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      rx_d     = rx_q;
      push     = 1'b0;
`ifdef SPI_SLAVE_RX_TIMEOUT_EN
      idle_cnt_d = idle_cnt_q;
`endif
      case (state_q)
         IDLE: begin
`ifdef SPI_SLAVE_RX_TIMEOUT_EN
            idle_cnt_d = '0;
`endif
            if (rise && selected) begin
               rx_d     = rx_shift;
               bitcnt_d = 3'd1;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            if (!selected) begin
               rx_d     = '0;
               bitcnt_d = '0;
               state_d  = IDLE;
            end else if (rise) begin
               rx_d = rx_shift;
`ifdef SPI_SLAVE_RX_TIMEOUT_EN
               idle_cnt_d = '0;
`endif
               if (bitcnt_q == 3'd7) begin
                  push     = 1'b1;
                  bitcnt_d = '0;
                  state_d  = IDLE;
               end else begin
                  bitcnt_d = bitcnt_q + 3'd1;
               end
`ifdef SPI_SLAVE_RX_TIMEOUT_EN
            end else if (idle_timeout) begin
               rx_d       = '0;
               bitcnt_d   = '0;
               idle_cnt_d = '0;
               state_d    = IDLE;
            end else begin
               idle_cnt_d = idle_cnt_q + 8'd1;
`endif
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Sticky overrun: a dropped byte sets it, and setting beats a clear
   always_comb begin
      overrun_d = overrun_q;
      if (Clr_i) begin
         overrun_d = 1'b0;
      end
      if (push && fifo_full && !Ready_i) begin
         overrun_d = 1'b1;
      end
   end

   // Synchronizer, FSM and overrun registers
   always_ff @(posedge Clk_i or negedge Rst_ni) begin
      if (!Rst_ni) begin
         sck_sync_q  <= '0;
         mosi_sync_q <= '0;
         ss_sync_q   <= '0;
         state_q     <= IDLE;
         bitcnt_q    <= '0;
         rx_q        <= '0;
         overrun_q   <= 1'b0;
`ifdef SPI_SLAVE_RX_TIMEOUT_EN
         idle_cnt_q  <= '0;
`endif
      end else begin
         sck_sync_q  <= sck_sync_d;
         mosi_sync_q <= mosi_sync_d;
         ss_sync_q   <= ss_sync_d;
         state_q     <= state_d;
         bitcnt_q    <= bitcnt_d;
         rx_q        <= rx_d;
         overrun_q   <= overrun_d;
`ifdef SPI_SLAVE_RX_TIMEOUT_EN
         idle_cnt_q  <= idle_cnt_d;
`endif
      end
   end

   spi_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .Clk_i   (Clk_i),
      .Rst_ni  (Rst_ni),
      .push_i  (push),
      .data_i  (rx_shift),
      .pop_i   (Ready_i),
      .data_o  (Data_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (Count_o)
   );

   assign Valid_o   = ~fifo_empty;
   assign Overrun_o = overrun_q;

endmodule
